memory_map: RTL and testbench
=============================

Name: memory_map

Overview:
- Memory subsystem directly downstream of the processor top.
- Consumes `address`, `to_memory` and `write`; produces `from_memory`.
- Decodes the 8-bit address space into four regions:
  - program ROM
  - data RAM
  - 16 registered output ports
  - 16 synchronised input ports
- Read data is registered, so the control unit FSM must spend one cycle between presenting an address and sampling `from_memory`.

Parameters:
- ROM_DEPTH, 128, ROM bytes at 0x00-0x7F.
- RAM_DEPTH, 96, RAM bytes at 0x80-0xDF.
- NUM_OUT, 16, output ports at 0xE0-0xEF.
- NUM_IN, 16, input ports at 0xF0-0xFF.
- SYNC_STAGES, 2, flop stages on each input port (minimum 2).
- Constraint: ROM_DEPTH+RAM_DEPTH+NUM_OUT+NUM_IN == 256; elaboration error otherwise.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  8  byte address from the datapath MAR
- to_memory  input  8  write data from the datapath
- write  input  1  write strobe from the control unit, sampled on rising clock
- from_memory  output  8  registered read data to the datapath
- port_in  input  8*NUM_IN  external inputs; port k = bits [8k+7:8k]
- port_out  output  8*NUM_OUT  registered output ports; port k = bits [8k+7:8k]

Behaviour:
- Reset is asynchronous and active-high, with these values while `reset` is high:
  - `from_memory` = 0x00
  - all `port_out` bytes = 0x00
  - all synchroniser flops = 0x00
  - RAM contents not reset (undefined until written); ROM is constant.
- Decode is combinational on `address`:
  - ROM: addr < 0x80
  - RAM: 0x80-0xDF
  - OUT: 0xE0-0xEF
  - IN: 0xF0-0xFF
- Region index = address minus region base; no wrap, since the regions tile 256 exactly.
- Read, every clock with `write` low or high:
  - `from_memory` <= content of the decoded location.
  - Latency is exactly 1 cycle: address at edge N, data valid after edge N+1.
- Read sources per region:
  - ROM returns the package ROM image byte.
  - RAM returns the stored byte.
  - OUT returns the current `port_out` register value (readback).
  - IN returns the last synchroniser stage.
- Write, `write`=1 at rising edge:
  - RAM: store `to_memory`.
  - OUT: `port_out[k]` <= `to_memory`.
  - ROM and IN regions: write ignored, no state change.
- Simultaneous read and write to the same address in one cycle is read-first: `from_memory` gets the old value; the new value is visible on the next read.
- Input ports:
  - Each bit passes through SYNC_STAGES flops.
  - A change on `port_in` is visible to a read issued SYNC_STAGES cycles later.
  - No debounce.
- Reset mid-operation:
  - An in-flight write at the same edge as reset assertion is lost for ports.
  - RAM write on that edge is don't-care.
  - The first read after deassertion behaves normally.
- Only one register stage on `from_memory`; no combinational path from `address` to `from_memory`.

Optional Feature:
- Macro: MEMORY_FAULT_EN.
- Defined:
  - Adds output port `mem_fault` (1 bit) and `fault_addr` (8 bits).
  - A write to the ROM or IN region sets `mem_fault`=1 (sticky) and captures `address` into `fault_addr`, first fault only.
  - Both are cleared only by reset; reset values are 0.
  - Ignored-write behaviour is otherwise unchanged.
- Undefined: ports absent; illegal writes are silently ignored.

Decomposition:
- Package memory_map_pkg holds:
  - region base constants: ROM_BASE=0x00, RAM_BASE=0x80, OUT_BASE=0xE0, IN_BASE=0xF0
  - a region enum type: REG_ROM, REG_RAM, REG_OUT, REG_IN
  - the ROM image constant array (program), built from the shared opcode constants also used by control_unit.
- Sub-module port_in_sync: a SYNC_STAGES-deep, 8-bit synchroniser with asynchronous reset; NUM_IN instances.

Test Plan:
- Reset asserted while `port_out` holds nonzero values -> `from_memory`=0x00 and all `port_out`=0x00 immediately, without waiting for a clock edge.
- Read 0x00 and 0x7F -> `from_memory` equals ROM image bytes 0 and 127, each exactly one cycle after the address is applied.
- Write 0xA5 to 0x80, write 0x3C to 0xDF, then read both -> 0xA5 and 0x3C. Write-and-read 0x80 with 0x11 in the same cycle -> old 0xA5 returned; next read gives 0x11.
- Write 0x5A to 0xE3 -> `port_out[3]`=0x5A after that edge, other ports remain 0x00. Read 0xE3 -> 0x5A.
- Set `port_in[15]`=0xC3 -> read of 0xFF issued 1 cycle later returns 0x00; read issued 2 cycles later returns 0xC3.
- Write 0xFF to 0x10 and to 0xF2 -> ROM byte and IN readback unchanged. With MEMORY_FAULT_EN: `mem_fault`=1 and `fault_addr`=0x10 (the second fault does not overwrite it).

Source files
------------

// File: rtl/memory_map_pkg.sv
// Shared constants for the memory subsystem: region bases, region tags,
// opcode encodings (shared with the control unit) and the program ROM image.
package memory_map_pkg;

  localparam logic [7:0] ROM_BASE = 8'h00;
  localparam logic [7:0] RAM_BASE = 8'h80;
  localparam logic [7:0] OUT_BASE = 8'hE0;
  localparam logic [7:0] IN_BASE  = 8'hF0;

  localparam int ROM_SIZE = 128;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_OUT,
    REG_IN
  } region_e;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h10;
  localparam logic [7:0] OP_STA = 8'h20;
  localparam logic [7:0] OP_ADD = 8'h30;
  localparam logic [7:0] OP_JMP = 8'h40;
  localparam logic [7:0] OP_HLT = 8'hF0;

  typedef logic [7:0] rom_t [ROM_SIZE];

  // Program: acc = in[0] + ram[0x80]; out[0] = acc; loop. Small table at 0x10.
  localparam rom_t ROM_IMAGE = '{
    0:   OP_LDA, 1: 8'hF0,
    2:   OP_ADD, 3: 8'h80,
    4:   OP_STA, 5: 8'hE0,
    6:   OP_JMP, 7: 8'h00,
    16:  8'h01, 17: 8'h02, 18: 8'h04, 19: 8'h08,
    127: OP_HLT,
    default: OP_NOP
  };

endpackage

// File: rtl/memory_map_port_in_sync.sv
// Multi-flop synchroniser for one 8-bit external input port, async reset to 0.
module port_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("port_in_sync: SYNC_STAGES must be at least 2");
  end

  logic [7:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_stage[k] <= 8'h00;
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < SYNC_STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_data = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/memory_map.sv
// Byte-addressed memory map: ROM, RAM, output ports, synchronised input ports.
// Optional MEMORY_FAULT_EN adds sticky illegal-write fault reporting.
module memory_map
  import memory_map_pkg::*;
#(
  parameter int ROM_DEPTH   = 128,
  parameter int RAM_DEPTH   = 96,
  parameter int NUM_OUT     = 16,
  parameter int NUM_IN      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           address,
  input  logic [7:0]           to_memory,
  input  logic                 write,
  output logic [7:0]           from_memory,
  input  logic [8*NUM_IN-1:0]  port_in,
  output logic [8*NUM_OUT-1:0] port_out
`ifdef MEMORY_FAULT_EN
  ,
  output logic                 mem_fault,
  output logic [7:0]           fault_addr
`endif
);

  if (ROM_DEPTH + RAM_DEPTH + NUM_OUT + NUM_IN != 256) begin : g_bad_map
    $error("memory_map: region sizes must total 256 bytes");
  end
  if (ROM_DEPTH > ROM_SIZE) begin : g_bad_rom
    $error("memory_map: ROM_DEPTH exceeds ROM image size");
  end

  localparam logic [7:0] RAM_B = 8'(ROM_BASE + ROM_DEPTH);
  localparam logic [7:0] OUT_B = 8'(RAM_B + RAM_DEPTH);
  localparam logic [7:0] IN_B  = 8'(OUT_B + NUM_OUT);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int OUT_AW = $clog2(NUM_OUT);
  localparam int IN_AW  = $clog2(NUM_IN);
  localparam int IDX_W  = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

  region_e          w_region;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_rd_data;
  logic             w_wr_ram;
  logic             w_wr_out;
  logic [7:0]       w_sync [NUM_IN];

  logic [7:0]       r_from;
  logic [7:0]       r_out [NUM_OUT];
  logic [7:0]       r_ram [RAM_DEPTH];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    port_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock  (clock),
      .reset  (reset),
      .i_data (port_in[8*k +: 8]),
      .o_data (w_sync[k])
    );
  end

  always_comb begin
    w_region = REG_IN;
    w_idx    = IDX_W'(address - IN_B);
    if (address < RAM_B) begin
      w_region = REG_ROM;
      w_idx    = IDX_W'(address - ROM_BASE);
    end else if (address < OUT_B) begin
      w_region = REG_RAM;
      w_idx    = IDX_W'(address - RAM_B);
    end else if (address < IN_B) begin
      w_region = REG_OUT;
      w_idx    = IDX_W'(address - OUT_B);
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_region)
      REG_ROM: w_rd_data = ROM_IMAGE[w_idx[ROM_AW-1:0]];
      REG_RAM: w_rd_data = r_ram[w_idx[RAM_AW-1:0]];
      REG_OUT: w_rd_data = r_out[w_idx[OUT_AW-1:0]];
      REG_IN:  w_rd_data = w_sync[w_idx[IN_AW-1:0]];
      default: w_rd_data = 8'h00;
    endcase
  end

  assign w_wr_ram = write && (w_region == REG_RAM);
  assign w_wr_out = write && (w_region == REG_OUT);

  // RAM is not reset; the read mux samples the old word, giving read-first.
  always_ff @(posedge clock) begin
    if (w_wr_ram) r_ram[w_idx[RAM_AW-1:0]] <= to_memory;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_from <= 8'h00;
      for (int k = 0; k < NUM_OUT; k++) r_out[k] <= 8'h00;
    end else begin
      r_from <= w_rd_data;
      if (w_wr_out) r_out[w_idx[OUT_AW-1:0]] <= to_memory;
    end
  end

  assign from_memory = r_from;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign port_out[8*k +: 8] = r_out[k];
  end

`ifdef MEMORY_FAULT_EN
  logic       r_fault;
  logic [7:0] r_fault_addr;

  // Only the first illegal write is captured; later ones leave the address alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 8'h00;
    end else if (write && !r_fault &&
                 ((w_region == REG_ROM) || (w_region == REG_IN))) begin
      r_fault      <= 1'b1;
      r_fault_addr <= address;
    end
  end

  assign mem_fault  = r_fault;
  assign fault_addr = r_fault_addr;
`endif

endmodule

// File: tb/tb_memory_map.sv
// Directed bench for memory_map with hand-computed expected values.
module tb_memory_map;

  logic         clock = 1'b0;
  logic         reset;
  logic         write;
  logic [7:0]   address;
  logic [7:0]   to_memory;
  logic [7:0]   from_memory;
  logic [127:0] port_in;
  logic [127:0] port_out;
`ifdef MEMORY_FAULT_EN
  logic         mem_fault;
  logic [7:0]   fault_addr;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  memory_map dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .to_memory   (to_memory),
    .write       (write),
    .from_memory (from_memory),
    .port_in     (port_in),
    .port_out    (port_out)
`ifdef MEMORY_FAULT_EN
    ,
    .mem_fault   (mem_fault),
    .fault_addr  (fault_addr)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    write     = 1'b0;
    address   = 8'h00;
    to_memory = 8'h00;
    port_in   = '0;
    port_in[23:16] = 8'h9D;
    step();
    step();
    check("reset_from_memory", from_memory, 8'h00);
    check("reset_port_out", port_out, '0);
`ifdef MEMORY_FAULT_EN
    check("reset_mem_fault", mem_fault, 1'b0);
    check("reset_fault_addr", fault_addr, 8'h00);
`endif
    reset = 1'b0;

    // load two output ports, then reset asynchronously mid-cycle
    write = 1'b1; address = 8'hE0; to_memory = 8'h77; step();
    address = 8'hEF; to_memory = 8'h66; step();
    write = 1'b0; address = 8'hE0; step();
    check("out_before_reset", port_out, {8'h66, 112'h0, 8'h77});
    check("out_readback_e0", from_memory, 8'h77);
    #1 reset = 1'b1;
    #1;
    check("async_reset_from_memory", from_memory, 8'h00);
    check("async_reset_port_out", port_out, '0);
    reset = 1'b0;

    // ROM reads, one-cycle latency, no combinational path
    address = 8'h00; step();
    check("rom_0x00", from_memory, 8'h10);
    address = 8'h7F; #1;
    check("rom_latency_hold", from_memory, 8'h10);
    step();
    check("rom_0x7f", from_memory, 8'hF0);

    // RAM write/read and read-first collision
    write = 1'b1; address = 8'h80; to_memory = 8'hA5; step();
    address = 8'hDF; to_memory = 8'h3C; step();
    write = 1'b0; address = 8'h80; step();
    check("ram_0x80", from_memory, 8'hA5);
    address = 8'hDF; step();
    check("ram_0xdf", from_memory, 8'h3C);
    write = 1'b1; address = 8'h80; to_memory = 8'h11; step();
    check("ram_read_first", from_memory, 8'hA5);
    write = 1'b0; step();
    check("ram_after_rw", from_memory, 8'h11);

    // output port write and readback
    write = 1'b1; address = 8'hE3; to_memory = 8'h5A; step();
    write = 1'b0;
    check("out3_write", port_out, 128'h5A << 24);
    step();
    check("out3_readback", from_memory, 8'h5A);

    // input port synchroniser latency
    address = 8'h00; port_in[127:120] = 8'hC3; step();
    address = 8'hFF; step();
    check("in15_one_cycle", from_memory, 8'h00);
    step();
    check("in15_two_cycles", from_memory, 8'hC3);

    // illegal writes to ROM and IN
    write = 1'b1; address = 8'h10; to_memory = 8'hFF; step();
    address = 8'hF2; step();
    write = 1'b0; address = 8'h10; step();
    check("rom_write_ignored", from_memory, 8'h01);
    address = 8'hF2; step();
    check("in_write_ignored", from_memory, 8'h9D);
`ifdef MEMORY_FAULT_EN
    check("fault_sticky", mem_fault, 1'b1);
    check("fault_first_addr", fault_addr, 8'h10);
`endif

    // port write coinciding with reset assertion is lost
    write = 1'b1; address = 8'hE5; to_memory = 8'h42; reset = 1'b1; step();
    reset = 1'b0; write = 1'b0;
    check("write_lost_on_reset", port_out, '0);
    address = 8'h7F; step();
    check("first_read_after_reset", from_memory, 8'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
